pwmled_fade_ctrl: RTL
=====================

PWMLED_FADE_CTRL -- requirements
Module: pwmled_fade_ctrl

Interface
REQ-001 The block SHALL have parameter PWM_BITS, default 8: PWM counter and level width.
REQ-002 The block SHALL have parameter STEP_BITS, default 16: fade step-interval width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock domain, 100 MHz nominal.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port avs_address, input, 2 bits: register select.
REQ-006 The block SHALL have ports avs_write and avs_read, input, 1 bit each: Avalon-MM strobes.
REQ-007 The block SHALL have port avs_writedata, input, 32 bits; and avs_readdata, output, 32 bits.
REQ-008 The block SHALL have port pwmled_out, output, 1 bit: PWM drive to the LED.
REQ-009 The block SHALL have port irq, output, 1 bit, present only with PWMLED_IRQ_EN.

Function
REQ-010 The register map SHALL be: 0 CTRL (bit0 enable, bit1 fade mode, bit2 done-clear W1C-strobe); 1 DUTY [PWM_BITS-1:0]; 2 STEP [STEP_BITS-1:0]; 3 STATUS, read-only.
REQ-011 STATUS SHALL be: [1:0] state, [PWM_BITS+1:2] current level, bit PWM_BITS+2 done sticky; unused bits read 0.
REQ-012 Reads SHALL have fixed 1-cycle latency, with registered avs_readdata; there are no wait states; writes SHALL take effect on the next clk edge.
REQ-013 The PWM counter SHALL free-run 0..2^PWM_BITS-1 and wrap while enable=1, and SHALL hold at 0 while enable=0.
REQ-014 pwmled_out SHALL be registered: 1 when counter < level, else 0; level 0 -> constant 0; max level -> high 255 of 256 counts.
REQ-015 The FSM SHALL have states IDLE(0), STATIC(1), RAMP_UP(2), RAMP_DOWN(3).
REQ-016 In IDLE: level=0, out=0; enable=1 & fade=0 -> STATIC; enable=1 & fade=1 -> RAMP_UP.
REQ-017 In STATIC, level SHALL track DUTY, updating only at counter wrap to avoid glitch periods.
REQ-018 Fade timing: a step counter SHALL increment at each PWM wrap; when it reaches STEP (STEP=0 treated as 1), it SHALL clear and the level SHALL step by 1.
REQ-019 In RAMP_UP, level SHALL increment per step until level==DUTY, then -> RAMP_DOWN; if DUTY<level (rewritten), it SHALL -> RAMP_DOWN at the next step without incrementing.
REQ-020 In RAMP_DOWN, level SHALL decrement per step; on reaching 0 it SHALL set done sticky and -> RAMP_UP.
REQ-021 DUTY=0 in fade mode SHALL keep level 0, with done set on each step.
REQ-022 Writing enable=0 from any state SHALL force IDLE, level 0, out 0, and counters 0 on the next cycle.
REQ-023 Toggling the fade bit while enabled SHALL transfer at the next PWM wrap: STATIC->RAMP_UP from the current level, ramp->STATIC.
REQ-024 Done-clear and done-set in the same cycle -> set SHALL win.
REQ-025 Level arithmetic SHALL saturate: no wrap below 0 or above 2^PWM_BITS-1.

Reset
REQ-026 On reset, all registers, counters, and level SHALL be 0, state IDLE, pwmled_out=0, avs_readdata=0, irq=0.
REQ-027 Reset asserted mid-ramp SHALL abort the ramp within 1 cycle, with no residual output pulse.

Configuration
REQ-028 With PWMLED_IRQ_EN defined, irq SHALL equal done sticky & CTRL bit3 (irq enable), and SHALL clear via done-clear.
REQ-029 Without PWMLED_IRQ_EN, the irq port and CTRL bit3 SHALL be absent; bit3 reads 0, and polling of STATUS is unchanged.

Verification
REQ-030 Scenario: reset, read STATUS -> 0x0; pwmled_out=0 for 1000 cycles.
REQ-031 Scenario: DUTY=64, CTRL=0x1 -> state STATIC; out high exactly 64 of every 256 cycles.
REQ-032 Scenario: DUTY=4, STEP=2, CTRL=0x3 -> level 0,1,2,3,4,3,2,1,0, each held 512 cycles; done set at return to 0.
REQ-033 Scenario: mid-RAMP_UP at level 10, write DUTY=5 -> next step enters RAMP_DOWN, level 9.
REQ-034 Scenario: mid-ramp, write CTRL=0x0 -> next cycle STATUS state=0, level 0, out 0.
REQ-035 Scenario (IRQ build): CTRL=0xB, DUTY=1, STEP=1 -> irq rises at level return to 0; write CTRL=0xF in the same cycle as a new done event -> irq stays 1.

Source files
------------

// File: rtl/pwmled_fade_ctrl.sv
// pwmled_fade_ctrl: Avalon-MM controlled LED PWM driver with static duty and triangular fade.
// Latency: reads return registered data 1 cycle after avs_read; writes act on the next clk edge.
// Backpressure: none, the slave never stalls. Optional irq output with macro PWMLED_IRQ_EN.
module pwmled_fade_ctrl #(
  parameter int PWM_BITS  = 8,
  parameter int STEP_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic        avs_read,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        pwmled_out
`ifdef PWMLED_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STATIC    = 2'd1,
    ST_RAMP_UP   = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  // Configuration registers
  logic                 r_ctrl_en;
  logic                 r_ctrl_fade;
`ifdef PWMLED_IRQ_EN
  logic                 r_ctrl_irqen;
`endif
  logic [PWM_BITS-1:0]  r_duty;
  logic [STEP_BITS-1:0] r_step;

  // Datapath state
  state_t               r_state;
  logic [PWM_BITS-1:0]  r_cnt;
  logic [PWM_BITS-1:0]  r_level;
  logic [STEP_BITS-1:0] r_step_cnt;
  logic                 r_done;
  logic                 r_out;
  logic [31:0]          r_rdata;

  // Combinational helpers
  logic                 w_ctrl_wr;
  logic                 w_en_nxt;
  logic                 w_done_clr;
  logic                 w_wrap;
  logic                 w_ramp;
  logic [STEP_BITS-1:0] w_step_eff;
  logic [STEP_BITS:0]   w_step_cnt_inc;
  logic                 w_step_hit;
  logic                 w_step_evt;
  logic [PWM_BITS-1:0]  w_lvl_inc;
  logic [PWM_BITS-1:0]  w_lvl_dec;
  state_t               w_state_nxt;
  logic [PWM_BITS-1:0]  w_level_nxt;
  logic [STEP_BITS-1:0] w_step_cnt_nxt;
  logic                 w_done_set;
  logic                 w_out_nxt;
  logic [31:0]          w_status;
  logic [31:0]          w_rd_mux;
  logic                 w_unused_wdata;

  // Upper write-data bits are ignored by every register.
  assign w_unused_wdata = ^avs_writedata;

  assign w_ctrl_wr  = avs_write && (avs_address == 2'd0);
  // Enable as it will be after this edge; a disabling write collapses everything at once.
  assign w_en_nxt   = w_ctrl_wr ? avs_writedata[0] : r_ctrl_en;
  assign w_done_clr = w_ctrl_wr && avs_writedata[2];

  assign w_wrap         = r_ctrl_en && (r_cnt == {PWM_BITS{1'b1}});
  assign w_ramp         = (r_state == ST_RAMP_UP) || (r_state == ST_RAMP_DOWN);
  // A step interval of 0 behaves like 1 so the fade never stalls.
  assign w_step_eff     = (r_step == '0) ? STEP_BITS'(1) : r_step;
  assign w_step_cnt_inc = {1'b0, r_step_cnt} + 1'b1;
  assign w_step_hit     = w_step_cnt_inc >= {1'b0, w_step_eff};
  assign w_step_evt     = w_wrap && w_ramp && w_step_hit;

  // Saturating level arithmetic
  assign w_lvl_inc = (r_level == {PWM_BITS{1'b1}}) ? r_level : r_level + 1'b1;
  assign w_lvl_dec = (r_level == '0) ? r_level : r_level - 1'b1;

  // Configuration register writes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl_en   <= 1'b0;
      r_ctrl_fade <= 1'b0;
`ifdef PWMLED_IRQ_EN
      r_ctrl_irqen <= 1'b0;
`endif
      r_duty      <= '0;
      r_step      <= '0;
    end else if (avs_write) begin
      case (avs_address)
        2'd0: begin
          r_ctrl_en   <= avs_writedata[0];
          r_ctrl_fade <= avs_writedata[1];
`ifdef PWMLED_IRQ_EN
          r_ctrl_irqen <= avs_writedata[3];
`endif
        end
        2'd1:    r_duty <= avs_writedata[PWM_BITS-1:0];
        2'd2:    r_step <= avs_writedata[STEP_BITS-1:0];
        default: ;
      endcase
    end
  end

  // FSM state register; disabling forces IDLE immediately
  always_ff @(posedge clk) begin
    if (reset || !w_en_nxt) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state plus level / done decisions taken at PWM wraps
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_done_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_level_nxt = '0;
        if (r_ctrl_en) begin
          if (r_ctrl_fade) begin
            w_state_nxt = ST_RAMP_UP;
          end else begin
            // Counter is at the start of a period here, so load the duty directly.
            w_state_nxt = ST_STATIC;
            w_level_nxt = r_duty;
          end
        end
      end
      ST_STATIC: begin
        if (w_wrap) begin
          if (r_ctrl_fade) begin
            w_state_nxt = ST_RAMP_UP;
          end else begin
            w_level_nxt = r_duty;
          end
        end
      end
      ST_RAMP_UP: begin
        if (w_wrap && !r_ctrl_fade) begin
          w_state_nxt = ST_STATIC;
          w_level_nxt = r_duty;
        end else if (w_step_evt) begin
          if (r_level < r_duty) begin
            w_level_nxt = w_lvl_inc;
            if (w_lvl_inc == r_duty) begin
              w_state_nxt = ST_RAMP_DOWN;
            end
          end else if (r_level == '0) begin
            // Duty of zero: the ramp degenerates to a done pulse every step.
            w_done_set = 1'b1;
          end else begin
            // Duty rewritten below the level: turn around without climbing.
            w_level_nxt = w_lvl_dec;
            if (w_lvl_dec == '0) begin
              w_done_set = 1'b1;
            end else begin
              w_state_nxt = ST_RAMP_DOWN;
            end
          end
        end
      end
      ST_RAMP_DOWN: begin
        if (w_wrap && !r_ctrl_fade) begin
          w_state_nxt = ST_STATIC;
          w_level_nxt = r_duty;
        end else if (w_step_evt) begin
          w_level_nxt = w_lvl_dec;
          if (w_lvl_dec == '0) begin
            w_done_set  = 1'b1;
            w_state_nxt = ST_RAMP_UP;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_level_nxt = '0;
      end
    endcase
  end

  // Step counter advances per wrap only while ramping
  always_comb begin
    w_step_cnt_nxt = r_step_cnt;
    if (!w_ramp) begin
      w_step_cnt_nxt = '0;
    end else if (w_wrap) begin
      w_step_cnt_nxt = w_step_hit ? '0 : w_step_cnt_inc[STEP_BITS-1:0];
    end
  end

  // Output decode: PWM compare, STATUS word and read mux
  always_comb begin
    w_out_nxt = (r_state != ST_IDLE) && (r_cnt < r_level);
    w_status = '0;
    w_status[1:0]            = r_state;
    w_status[PWM_BITS+1:2]   = r_level;
    w_status[PWM_BITS+2]     = r_done;
    w_rd_mux = '0;
    case (avs_address)
      2'd0: begin
        w_rd_mux[0] = r_ctrl_en;
        w_rd_mux[1] = r_ctrl_fade;
`ifdef PWMLED_IRQ_EN
        w_rd_mux[3] = r_ctrl_irqen;
`endif
      end
      2'd1:    w_rd_mux[PWM_BITS-1:0]  = r_duty;
      2'd2:    w_rd_mux[STEP_BITS-1:0] = r_step;
      default: w_rd_mux = w_status;
    endcase
  end

  // PWM counter, level, step counter and LED output
  always_ff @(posedge clk) begin
    if (reset || !w_en_nxt) begin
      r_cnt      <= '0;
      r_level    <= '0;
      r_step_cnt <= '0;
      r_out      <= 1'b0;
    end else begin
      if (r_ctrl_en) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_level    <= w_level_nxt;
      r_step_cnt <= w_step_cnt_nxt;
      r_out      <= w_out_nxt;
    end
  end

  // Sticky done flag; a same-cycle set beats the clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done <= 1'b0;
    end else if (w_done_set && w_en_nxt) begin
      r_done <= 1'b1;
    end else if (w_done_clr) begin
      r_done <= 1'b0;
    end
  end

  // Registered read data, updated only on a read strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (avs_read) begin
      r_rdata <= w_rd_mux;
    end
  end

  assign avs_readdata = r_rdata;
  assign pwmled_out   = r_out;
`ifdef PWMLED_IRQ_EN
  assign irq = r_done && r_ctrl_irqen;
`endif

endmodule
